// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment MMIO display peripheral.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Holds register offsets, CTRL bit positions, the hex-to-segment patterns,
// the blank pattern, the digit count and the BCD converter state encoding.
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;

   // Register byte offsets (address[1:0] is ignored by the decoder)
   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_CTRL   = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;

   // CTRL layout
   localparam int unsigned CTRL_EN_BIT    = 0;
   localparam int unsigned CTRL_DEC_BIT   = 1;
   localparam int unsigned CTRL_BLANK_LSB = 4;
   localparam logic [7:0]  CTRL_RESET     = 8'h01;

   // Segment patterns {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   // Decimal conversion: 9999 fits in 14 bits, so 14 shift steps suffice
   localparam int unsigned BCD_BITS  = 14;
   localparam logic [15:0] BCD_LIMIT = 16'd9999;

   typedef enum logic {
      CONV_IDLE,
      CONV_RUN
   } conv_state_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = SEG_0;
         4'h1: s = SEG_1;
         4'h2: s = SEG_2;
         4'h3: s = SEG_3;
         4'h4: s = SEG_4;
         4'h5: s = SEG_5;
         4'h6: s = SEG_6;
         4'h7: s = SEG_7;
         4'h8: s = SEG_8;
         4'h9: s = SEG_9;
         4'hA: s = SEG_A;
         4'hB: s = SEG_B;
         4'hC: s = SEG_C;
         4'hD: s = SEG_D;
         4'hE: s = SEG_E;
         default: s = SEG_F;
      endcase
      return s;
   endfunction

   // Saturate to the largest four-digit decimal value
   function automatic logic [BCD_BITS-1:0] clamp_9999(input logic [15:0] v);
      logic [15:0] c;
      c = (v > BCD_LIMIT) ? BCD_LIMIT : v;
      return c[BCD_BITS-1:0];
   endfunction

   // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift
   function automatic logic [15:0] bcd_adjust(input logic [15:0] w);
      logic [15:0] r;
      r = w;
      for (int i = 0; i < 4; i++) begin
         if (w[i*4 +: 4] > 4'd4) begin
            r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
// Latency: 14 cycles from start to done; busy is high for those 14 cycles.
// Backpressure: none; a start while busy discards the conversion and restarts.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         load bin and begin a conversion (values > 9999 saturate)
//   bin[15:0]     binary value sampled on the start edge
//   busy          conversion in progress
//   done          one-cycle pulse on the edge that publishes bcd
//   bcd[15:0]     last completed result, four BCD digits; held while busy
module seg7_bcd_conv
   import seg7_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd
);

   conv_state_t         state_q, state_n;
   logic [BCD_BITS-1:0] bin_q, bin_n;
   logic [15:0]         work_q, work_n;
   logic [3:0]          step_q, step_n;
   logic [15:0]         bcd_q, bcd_n;
   logic                done_q, done_n;
   logic [15:0]         shifted;

   // Adjust then shift the next binary MSB into the BCD accumulator
   always_comb begin
      logic [15:0] adj;
      adj     = bcd_adjust(work_q);
      shifted = {adj[14:0], bin_q[BCD_BITS-1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CONV_IDLE;
         bin_q   <= '0;
         work_q  <= '0;
         step_q  <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         bin_q   <= bin_n;
         work_q  <= work_n;
         step_q  <= step_n;
         bcd_q   <= bcd_n;
         done_q  <= done_n;
      end
   end

   always_comb begin
      state_n = state_q;
      bin_n   = bin_q;
      work_n  = work_q;
      step_n  = step_q;
      bcd_n   = bcd_q;
      done_n  = 1'b0;
      if (start) begin
         state_n = CONV_RUN;
         bin_n   = clamp_9999(bin);
         work_n  = '0;
         step_n  = 4'(BCD_BITS);
      end else if (state_q == CONV_RUN) begin
         work_n = shifted;
         bin_n  = {bin_q[BCD_BITS-2:0], 1'b0};
         step_n = step_q - 4'd1;
         if (step_q == 4'd1) begin
            state_n = CONV_IDLE;
            bcd_n   = shifted;
            done_n  = 1'b1;
         end
      end
   end

   assign busy = (state_q == CONV_RUN);
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_mmio_responder.sv
// Memory-mapped four-digit seven-segment display peripheral (DATA/CTRL/STATUS).
// Latency: reads 1 cycle; a register write reaches seg/an one edge later.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// Optional feature: define SEG7_DECIMAL_EN for decimal display (CTRL.dec,
// STATUS.busy and the seg7_bcd_conv instance). Without it the block is hex-only.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   address[3:0]      byte offset; [1:0] ignored
//   readEnable        read strobe (decoder-gated); loads readData
//   writeEnable       write strobe (decoder-gated)
//   writeData[31:0]   store data
//   readData[31:0]    registered load data, held while readEnable is low
//   seg[6:0]          {g,f,e,d,c,b,a}, active-low
//   an[3:0]           digit anodes, active-low; an[0] is the rightmost digit
module seg7_mmio_responder
   import seg7_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  address,
   input  logic        readEnable,
   input  logic        writeEnable,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [3:0]       offset;
   logic             wr_data;
   logic             wr_ctrl;
   logic [15:0]      data_q;
   logic [7:0]       ctrl_q;
   logic [CNT_W-1:0] refresh_cnt;
   logic             refresh_wrap;
   logic [1:0]       digit_idx;
   logic [7:0]       frame_cnt;
   logic             busy;
   logic [15:0]      disp_val;
   logic [31:0]      rd_mux;
   logic [3:0]       nibble;
   logic [3:0]       blank_mask;
   logic             blank_now;

   assign offset  = {address[3:2], 2'b00};
   assign wr_data = writeEnable && (offset == OFF_DATA);
   assign wr_ctrl = writeEnable && (offset == OFF_CTRL);

`ifdef SEG7_DECIMAL_EN
   localparam logic [7:0] CTRL_WMASK = 8'hF3;

   logic        conv_start;
   logic [15:0] conv_in;
   logic        conv_busy;
   logic        conv_done;
   logic [15:0] bcd_val;

   // Convert on any DATA write, or when dec is switched on; a DATA write
   // takes the new value straight from the bus since data_q is not yet updated.
   assign conv_start = wr_data ||
                       (wr_ctrl && writeData[CTRL_DEC_BIT] && !ctrl_q[CTRL_DEC_BIT]);
   assign conv_in    = wr_data ? writeData[15:0] : data_q;

   seg7_bcd_conv u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (conv_in),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (bcd_val)
   );

   assign busy     = conv_busy;
   assign disp_val = ctrl_q[CTRL_DEC_BIT] ? bcd_val : data_q;

   logic unused_conv;
   assign unused_conv = conv_done;
`else
   localparam logic [7:0] CTRL_WMASK = 8'hF1;

   assign busy     = 1'b0;
   assign disp_val = data_q;
`endif

   // Upper store bits and the byte lane within a word carry no meaning here
   logic unused_bus;
   assign unused_bus = ^{writeData[31:16], address[1:0]};

   // Register file
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         ctrl_q <= CTRL_RESET;
      end else begin
         if (wr_data) data_q <= writeData[15:0];
         if (wr_ctrl) ctrl_q <= writeData[7:0] & CTRL_WMASK;
      end
   end

   // Read mux sees pre-write register values, so a same-offset read and
   // write in one cycle returns the old contents.
   always_comb begin
      rd_mux = '0;
      case (offset)
         OFF_DATA:   rd_mux = {16'h0, data_q};
         OFF_CTRL:   rd_mux = {24'h0, ctrl_q};
         OFF_STATUS: rd_mux = {16'h0, frame_cnt, 5'b0, busy, digit_idx};
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         readData <= '0;
      end else if (readEnable) begin
         readData <= rd_mux;
      end
   end

   // Refresh timebase: free-running, independent of en
   assign refresh_wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
         frame_cnt   <= '0;
      end else if (refresh_wrap) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + 2'd1;
         if (digit_idx == 2'(NUM_DIGITS - 1)) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end else begin
         refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
   end

   // Display drive, registered from the current digit slot
   assign nibble     = disp_val[{digit_idx, 2'b00} +: 4];
   assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: 4];
   assign blank_now  = !ctrl_q[CTRL_EN_BIT] || blank_mask[digit_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end else if (blank_now) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
      end else begin
         an  <= ~(4'b0001 << digit_idx);
         seg <= hex_to_seg(nibble);
      end
   end

endmodule
